// File: rtl/tlb_refill_pkg.sv
// tlb_refill_pkg: shared geometry, field widths, permission bit positions and FSM encoding for the TLB refill path
package tlb_refill_pkg;
    localparam int NUM_WAYS       = 4;
    localparam int NUM_SETS       = 16;
    localparam int SET_INDEX_BITS = 4;
    localparam int WAY_BITS       = $clog2(NUM_WAYS);
    localparam int VPN_W          = 20;
    localparam int PPN_W          = 20;
    localparam int PERM_BITS      = 2;
    localparam int PERM_R         = 0;
    localparam int PERM_W         = 1;
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_DRAIN
    } state_t;
endpackage

// File: rtl/tlb_refill_if.sv
// tlb_refill_if: miss, page-table-walk, array-write and completion signals of the refill block
// master: lookup/walker/array side; slave: tlb_refill itself
interface tlb_refill_if;
    import tlb_refill_pkg::*;
    logic                      miss_valid;
    logic                      miss_ready;
    logic [VPN_W-1:0]          miss_vpn;
    logic                      ptw_req_valid;
    logic                      ptw_req_ready;
    logic [VPN_W-1:0]          ptw_req_vpn;
    logic                      ptw_resp_valid;
    logic [PPN_W-1:0]          ptw_resp_ppn;
    logic [PERM_BITS-1:0]      ptw_resp_perms;
    logic                      ptw_resp_fault;
    logic [NUM_WAYS-1:0]       set_way_valid;
    logic                      wr_en;
    logic [SET_INDEX_BITS-1:0] wr_set;
    logic [WAY_BITS-1:0]       wr_way;
    logic [VPN_W-1:0]          wr_vpn;
    logic [PPN_W-1:0]          wr_ppn;
    logic [PERM_BITS-1:0]      wr_perms;
    logic                      done_valid;
    logic                      done_fault;
    logic                      flush;
    modport master (
        output miss_valid, miss_vpn, ptw_req_ready, ptw_resp_valid, ptw_resp_ppn,
               ptw_resp_perms, ptw_resp_fault, set_way_valid, flush,
        input  miss_ready, ptw_req_valid, ptw_req_vpn, wr_en, wr_set, wr_way,
               wr_vpn, wr_ppn, wr_perms, done_valid, done_fault
    );
    modport slave (
        input  miss_valid, miss_vpn, ptw_req_ready, ptw_resp_valid, ptw_resp_ppn,
               ptw_resp_perms, ptw_resp_fault, set_way_valid, flush,
        output miss_ready, ptw_req_valid, ptw_req_vpn, wr_en, wr_set, wr_way,
               wr_vpn, wr_ppn, wr_perms, done_valid, done_fault
    );
endinterface

// File: rtl/tlb_refill_victim_sel.sv
// tlb_refill_victim_sel: picks the lowest invalid way, falling back to the set's round-robin pointer when all are valid
// valid: per-way valid bits; rr_ptr: round-robin pointer of the set; way: victim; use_rr: fallback taken
module tlb_refill_victim_sel
    import tlb_refill_pkg::*;
(
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [WAY_BITS-1:0] rr_ptr,
    output logic [WAY_BITS-1:0] way,
    output logic                use_rr
);
    always_comb begin
        use_rr = &valid;
        way    = rr_ptr;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!valid[i]) way = WAY_BITS'(i);
    end
endmodule

// File: rtl/tlb_refill.sv
// tlb_refill: accepts a TLB miss, runs one page-table walk, picks a victim way and writes the TLB array
// clk/rst_n: clock and async active-low reset; bus: slave side of tlb_refill_if
module tlb_refill
    import tlb_refill_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    tlb_refill_if.slave bus
);
    state_t                    state, state_nx;
    logic [VPN_W-1:0]          vpn_q;
    logic [PPN_W-1:0]          ppn_q;
    logic [PERM_BITS-1:0]      perms_q;
    logic                      fault_q;
    logic [WAY_BITS-1:0]       rr_ptr [NUM_SETS];
    logic [SET_INDEX_BITS-1:0] set_idx;
    logic [WAY_BITS-1:0]       vic_way;
    logic                      use_rr;
    logic                      wr_fire;
    logic                      resp_take;

    assign set_idx   = vpn_q[SET_INDEX_BITS-1:0];
    assign wr_fire   = (state == S_WRITE) && !bus.flush;
    assign resp_take = (state == S_WAIT) && bus.ptw_resp_valid && !bus.flush;

    tlb_refill_victim_sel u_victim (
        .valid  (bus.set_way_valid),
        .rr_ptr (rr_ptr[set_idx]),
        .way    (vic_way),
        .use_rr (use_rr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            vpn_q   <= '0;
            ppn_q   <= '0;
            perms_q <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < NUM_SETS; i++) rr_ptr[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && bus.miss_valid && !bus.flush) vpn_q <= bus.miss_vpn;
            if (resp_take) begin
                ppn_q   <= bus.ptw_resp_ppn;
                perms_q <= {bus.ptw_resp_perms[PERM_W], bus.ptw_resp_perms[PERM_R]};
                fault_q <= bus.ptw_resp_fault;
            end
            if (bus.flush)
                for (int i = 0; i < NUM_SETS; i++) rr_ptr[i] <= '0;
            else if (wr_fire && use_rr)
                rr_ptr[set_idx] <= (rr_ptr[set_idx] == WAY_BITS'(NUM_WAYS - 1)) ? '0 : rr_ptr[set_idx] + WAY_BITS'(1);
        end
    end

    // Flush outranks every other transition; a request already handed to the
    // walker must have its response drained before a new miss is accepted.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = (bus.miss_valid && !bus.flush) ? S_REQ : S_IDLE;
            S_REQ:   state_nx = bus.flush ? (bus.ptw_req_ready ? S_DRAIN : S_IDLE)
                                          : (bus.ptw_req_ready ? S_WAIT : S_REQ);
            S_WAIT:  state_nx = bus.flush ? (bus.ptw_resp_valid ? S_IDLE : S_DRAIN)
                                          : (!bus.ptw_resp_valid ? S_WAIT : bus.ptw_resp_fault ? S_DONE : S_WRITE);
            S_WRITE: state_nx = bus.flush ? S_IDLE : S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_DRAIN: state_nx = bus.ptw_resp_valid ? S_IDLE : S_DRAIN;
            default: state_nx = S_IDLE;
        endcase
    end

    // miss_ready is gated by rst_n so every output reads 0 while reset is held.
    assign bus.miss_ready    = rst_n && (state == S_IDLE);
    assign bus.ptw_req_valid = (state == S_REQ);
    assign bus.ptw_req_vpn   = vpn_q;
    assign bus.wr_en         = wr_fire;
    assign bus.wr_set        = set_idx;
    assign bus.wr_way        = (state == S_WRITE) ? vic_way : '0;
    assign bus.wr_vpn        = vpn_q;
    assign bus.wr_ppn        = ppn_q;
    assign bus.wr_perms      = perms_q;
    assign bus.done_valid    = (state == S_DONE);
    assign bus.done_fault    = (state == S_DONE) && fault_q;
endmodule

// File: tb/tb_tlb_refill.sv
// tb_tlb_refill: randomized scoreboard bench for tlb_refill against a behavioural refill model
module tb_tlb_refill;
    typedef struct {
        logic [3:0]  set;
        logic [1:0]  way;
        logic [19:0] vpn;
        logic [19:0] ppn;
        logic [1:0]  perms;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    wr_t  wq[$];
    logic dq[$];
    int   rr_m[16];
    wr_t  mon_e;

    tlb_refill_if bus ();

    tlb_refill dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rr_clear();
        for (int i = 0; i < 16; i++) rr_m[i] = 0;
    endtask

    // Reference: first invalid way wins, else the set's round-robin pointer which then advances.
    task automatic model_push(input logic [19:0] vpn, input logic [19:0] ppn, input logic [1:0] perms,
                              input logic fault, input logic [3:0] vld);
        wr_t e;
        int  w = -1;
        int  s = int'(vpn[3:0]);
        if (fault) begin
            dq.push_back(1'b1);
            return;
        end
        for (int i = 0; i < 4; i++) if (!vld[i] && w < 0) w = i;
        if (w < 0) begin
            w = rr_m[s];
            rr_m[s] = (rr_m[s] + 1) % 4;
        end
        e.set = vpn[3:0];
        e.way = 2'(w);
        e.vpn = vpn;
        e.ppn = ppn;
        e.perms = perms;
        wq.push_back(e);
        dq.push_back(1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_miss_ready"}, bus.miss_ready, 0);
        chk({tag, "_req_valid"}, bus.ptw_req_valid, 0);
        chk({tag, "_req_vpn"}, bus.ptw_req_vpn, 0);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_wr_set"}, bus.wr_set, 0);
        chk({tag, "_wr_way"}, bus.wr_way, 0);
        chk({tag, "_wr_vpn"}, bus.wr_vpn, 0);
        chk({tag, "_wr_ppn"}, bus.wr_ppn, 0);
        chk({tag, "_wr_perms"}, bus.wr_perms, 0);
        chk({tag, "_done_valid"}, bus.done_valid, 0);
        chk({tag, "_done_fault"}, bus.done_fault, 0);
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (!bus.miss_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", bus.miss_ready, 1);
        step();
    endtask

    // fmode: 0 none, 1 flush in WAIT then late response, 2 flush in REQ,
    // 3 flush in WRITE, 4 flush coinciding with the response in WAIT
    task automatic refill(input logic [19:0] vpn, input logic [19:0] ppn, input logic [1:0] perms,
                          input logic fault, input logic [3:0] vld, input int req_dly,
                          input int resp_dly, input int fmode);
        bus.set_way_valid = vld;
        wait_idle();
        bus.miss_valid = 1'b1;
        bus.miss_vpn = vpn;
        step();
        bus.miss_valid = 1'b0;
        bus.miss_vpn = 20'($urandom);
        for (int i = 0; i < req_dly; i++) begin
            @(negedge clk);
            chk("stall_req_valid", bus.ptw_req_valid, 1);
            chk("stall_req_vpn", bus.ptw_req_vpn, vpn);
            step();
        end
        if (fmode == 2) begin
            bus.flush = 1'b1;
            step();
            bus.flush = 1'b0;
            rr_clear();
            @(negedge clk);
            chk("flush_req_ready", bus.miss_ready, 1);
            chk("flush_req_noreq", bus.ptw_req_valid, 0);
            return;
        end
        bus.ptw_req_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", bus.ptw_req_valid, 1);
        chk("req_vpn", bus.ptw_req_vpn, vpn);
        step();
        bus.ptw_req_ready = 1'b0;
        if (fmode == 1) begin
            bus.flush = 1'b1;
            step();
            bus.flush = 1'b0;
            rr_clear();
        end
        for (int i = 0; i < resp_dly; i++) step();
        if (fmode == 0) model_push(vpn, ppn, perms, fault, vld);
        if (fmode == 4) begin
            bus.flush = 1'b1;
            rr_clear();
        end
        bus.ptw_resp_valid = 1'b1;
        bus.ptw_resp_ppn = ppn;
        bus.ptw_resp_perms = perms;
        bus.ptw_resp_fault = fault;
        step();
        bus.flush = 1'b0;
        bus.ptw_resp_valid = 1'b0;
        bus.ptw_resp_ppn = 20'($urandom);
        bus.ptw_resp_perms = 2'($urandom);
        bus.ptw_resp_fault = 1'($urandom);
        if (fmode == 1 || fmode == 4) begin
            @(negedge clk);
            chk("flush_wait_ready", bus.miss_ready, 1);
            return;
        end
        if (fmode == 3) begin
            bus.flush = 1'b1;
            step();
            bus.flush = 1'b0;
            rr_clear();
            @(negedge clk);
            chk("flush_write_ready", bus.miss_ready, 1);
            return;
        end
        if (!fault) step();
        step();
        @(negedge clk);
        chk(fault ? "fault_ready" : "done_ready", bus.miss_ready, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                if (wq.size() == 0) chk("wr_unexpected", bus.wr_en, 0);
                else begin
                    mon_e = wq.pop_front();
                    chk("wr_set", bus.wr_set, mon_e.set);
                    chk("wr_way", bus.wr_way, mon_e.way);
                    chk("wr_vpn", bus.wr_vpn, mon_e.vpn);
                    chk("wr_ppn", bus.wr_ppn, mon_e.ppn);
                    chk("wr_perms", bus.wr_perms, mon_e.perms);
                end
            end
            if (bus.done_valid) begin
                if (dq.size() == 0) chk("done_unexpected", bus.done_valid, 0);
                else chk("done_fault", bus.done_fault, dq.pop_front());
            end
        end
    end

    initial begin
        bus.miss_valid = 1'b0;
        bus.miss_vpn = '0;
        bus.ptw_req_ready = 1'b0;
        bus.ptw_resp_valid = 1'b0;
        bus.ptw_resp_ppn = '0;
        bus.ptw_resp_perms = '0;
        bus.ptw_resp_fault = 1'b0;
        bus.set_way_valid = '0;
        bus.flush = 1'b0;
        rr_clear();
        #23;
        chk_zero("reset");
        rst_n = 1'b1;
        refill(20'h12345, 20'h54321, 2'b11, 1'b0, 4'b0000, 0, 3, 0);
        refill(20'h00A03, 20'h11111, 2'b01, 1'b0, 4'b0111, 0, 1, 0);
        refill(20'h00B03, 20'h22222, 2'b10, 1'b0, 4'b1111, 0, 0, 0);
        refill(20'h0010E, 20'h30000, 2'b01, 1'b0, 4'b1111, 0, 0, 0);
        refill(20'h0020E, 20'h30001, 2'b11, 1'b0, 4'b1111, 1, 2, 0);
        refill(20'h00305, 20'h30002, 2'b10, 1'b0, 4'b1111, 0, 0, 0);
        refill(20'h0040E, 20'h30003, 2'b01, 1'b0, 4'b1111, 0, 1, 0);
        refill(20'h0050E, 20'h30004, 2'b11, 1'b0, 4'b1111, 2, 0, 0);
        refill(20'h0060E, 20'h30005, 2'b10, 1'b0, 4'b1111, 0, 0, 0);
        refill(20'h7777E, 20'hDEAD0, 2'b11, 1'b1, 4'b1111, 0, 2, 0);
        refill(20'h0070E, 20'h40000, 2'b01, 1'b0, 4'b1111, 0, 0, 1);
        refill(20'h0080E, 20'h40001, 2'b11, 1'b0, 4'b1111, 0, 5, 1);
        refill(20'h0090E, 20'h40002, 2'b11, 1'b0, 4'b1111, 6, 1, 0);
        // Asynchronous reset in the middle of WAIT.
        bus.set_way_valid = 4'b1111;
        wait_idle();
        bus.miss_valid = 1'b1;
        bus.miss_vpn = 20'hABCDE;
        step();
        bus.miss_valid = 1'b0;
        bus.ptw_req_ready = 1'b1;
        step();
        bus.ptw_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        rr_clear();
        #1;
        chk_zero("midreset");
        #3;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("post_reset_ready", bus.miss_ready, 1);
        refill(20'h00A0E, 20'h50000, 2'b01, 1'b0, 4'b1111, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            logic [19:0] v = {16'($urandom), 2'b0, 2'($urandom)} | 20'h4;
            logic [3:0]  m = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            int          f = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
            logic        flt = (f == 0 || f == 1 || f == 4) && ($urandom_range(0, 7) == 0);
            refill(v, 20'($urandom), 2'($urandom), flt, m, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), f);
        end
        repeat (4) step();
        chk("wq_empty", 64'(wq.size()), 0);
        chk("dq_empty", 64'(dq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tlb_refill.md
Name: tlb_refill

Overview:
Write-side companion to the TLB lookup path: accepts a miss, runs one page-table-walk request/response exchange, selects a victim way, and drives the TLB array write port.
- Sits between the lookup/miss logic and the page-table walker.
- Owns the per-set round-robin replacement state.
- Handles exactly one refill at a time.

Parameters:
NUM_WAYS, 4, associativity; must match the lookup path.
NUM_SETS, 16, number of sets.
SET_INDEX_BITS, 4, log2(NUM_SETS); the set index is vpn[SET_INDEX_BITS-1:0].

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
miss_valid  in  1  miss request pending.
miss_ready  out  1  block can accept a miss; high only in IDLE.
miss_vpn  in  20  VPN that missed.
ptw_req_valid  out  1  walk request valid.
ptw_req_ready  in  1  walker accepts the request.
ptw_req_vpn  out  20  registered miss VPN.
ptw_resp_valid  in  1  walk response, one-cycle pulse.
ptw_resp_ppn  in  20  translated PPN.
ptw_resp_perms  in  2  {W,R} permission bits.
ptw_resp_fault  in  1  walk found no valid PTE.
set_way_valid  in  NUM_WAYS  array valid bits of the set on wr_set; combinational from the array.
wr_en  out  1  one-cycle array write strobe.
wr_set  out  SET_INDEX_BITS  target set; always = vpn_q[SET_INDEX_BITS-1:0].
wr_way  out  2  victim way.
wr_vpn / wr_ppn  out  20 / 20  entry contents.
wr_perms  out  2  entry permissions.
done_valid  out  1  one-cycle completion pulse.
done_fault  out  1  qualifies done_valid: walk faulted, nothing written.
flush  in  1  abort the refill in flight and clear replacement state.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; vpn_q = 0; all round-robin pointers = 0.
- States: IDLE, REQ, WAIT, WRITE, DONE, DRAIN.
- IDLE
  - miss_ready = 1.
  - On miss_valid: latch vpn_q <= miss_vpn, go to REQ.
- REQ
  - ptw_req_valid = 1; ptw_req_vpn = vpn_q held stable.
  - On ptw_req_ready: go to WAIT.
- WAIT, on ptw_resp_valid:
  - fault = 1: set done_fault, go to DONE. No write occurs.
  - Otherwise: latch ppn/perms, go to WRITE.
- WRITE, single cycle: wr_en = 1.
  - wr_way = lowest-index way with set_way_valid = 0.
  - If all ways are valid: wr_way = rr_ptr[set], then rr_ptr[set] increments mod NUM_WAYS.
  - rr_ptr is unchanged when an invalid way was used.
  - Go to DONE.
- DONE
  - done_valid = 1 for one cycle; done_fault holds the latched value; go to IDLE.
- Miss-to-done latency is 4 cycles plus walker delay.
  - Minimum, with same-cycle ready: IDLE→REQ 1, REQ→WAIT 1, WAIT→WRITE (response cycle), WRITE→DONE 1.
- Flush
  - Highest priority; in every state, all rr_ptr <= 0.
  - IDLE: no state change.
  - REQ without ptw_req_ready: go to IDLE; no request is issued.
  - REQ with ptw_req_ready same cycle: go to DRAIN.
  - WAIT: go to DRAIN, unless ptw_resp_valid is high that same cycle, then go to IDLE and discard the response.
  - DRAIN: wait for ptw_resp_valid, discard it, go to IDLE.
  - WRITE: write is suppressed (wr_en = 0), go to IDLE.
  - DONE: done_valid still pulses.
  - No done_valid is produced for a flushed refill.
- ptw_resp_valid outside WAIT/DRAIN is ignored. A miss_valid asserted while not in IDLE is not accepted.
- Reset mid-operation: immediate return to IDLE; outputs forced to reset values asynchronously.

Decomposition:
- Shared params header (tlb_params.vh):
  - NUM_WAYS, NUM_SETS, SET_INDEX_BITS, VPN/PPN widths (20).
  - Permission bit positions (R = bit0, W = bit1).
  - FSM state encodings.
- One natural sub-module, tlb_victim_sel:
  - Combinational first-invalid priority encoder with round-robin fallback.
  - Outputs way and a use_rr flag.

Test Plan:
- Basic refill: reset, miss_vpn=0x12345, ptw_req_ready=1, resp ppn=0x54321 perms=11 after 3 cycles -> wr_en once with set=0x5, way=0, vpn=0x12345, ppn=0x54321, perms=11; done_valid=1, done_fault=0.
- First-invalid choice: set_way_valid=4'b0111 -> wr_way=3; rr_ptr[set] unchanged.
- Round-robin: set_way_valid=4'b1111, four refills to set 0xE -> wr_way sequence 0,1,2,3 then 0; a refill to set 0x5 in between uses way 0 for set 0x5.
- Walk fault: resp fault=1 -> no wr_en; done_valid=1 with done_fault=1; miss_ready=1 the next cycle.
- Flush in WAIT: flush one cycle after request acceptance, response arrives 5 cycles later -> FSM DRAIN, no wr_en, no done_valid, miss_ready=1 the cycle after the response.
- Handshake stall and reset: ptw_req_ready low for 6 cycles -> ptw_req_valid held with stable vpn; rst_n dropped mid-WAIT -> all outputs 0 immediately, miss_ready=1 after release.
